muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: a radix-2 shift-add multiplier and a restoring divider.
// Each produces one bit per cycle, and the result is written through the register-file port.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] DataA,
  input  logic [31:0] DataB,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        WE,
  output logic [4:0]  AddD,
  output logic [31:0] DataD
);

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_q, neg_d;
  logic        spec_q, spec_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  addd_q, addd_d;

  // Operand decode on the latched request
  logic        is_div, is_rem, a_signed, b_signed, neg_a, neg_b, neg_res;
  logic        div_zero, div_ovf, special;
  logic [31:0] mag_a, mag_b, spec_val;

  always_comb begin
    is_div   = op_q[2];
    is_rem   = op_q[2] & op_q[1];
    a_signed = is_div ? ~op_q[0] : (op_q != OpMulhu);
    b_signed = is_div ? ~op_q[0] : ~op_q[1];
    neg_a    = a_signed & a_q[31];
    neg_b    = b_signed & b_q[31];
    mag_a    = neg_a ? (~a_q + 32'd1) : a_q;
    mag_b    = neg_b ? (~b_q + 32'd1) : b_q;
    // Remainder follows the dividend sign; everything else is the sign product
    neg_res  = is_rem ? neg_a : (neg_a ^ neg_b);
    div_zero = is_div & (b_q == 32'd0);
    div_ovf  = is_div & ~op_q[0] & (a_q == 32'h8000_0000) & (b_q == 32'hFFFF_FFFF);
    special  = div_zero | div_ovf;
    if (div_zero) begin
      spec_val = is_rem ? a_q : 32'hFFFF_FFFF;
    end else begin
      spec_val = is_rem ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration of each algorithm; acc holds {high, low} working halves
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] r_sh;
  logic        r_ge;
  logic [31:0] new_rem;
  logic [63:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    r_sh     = acc_q[63:31];
    r_ge     = (r_sh >= {1'b0, opnd_q});
    new_rem  = r_ge ? 32'(r_sh - {1'b0, opnd_q}) : r_sh[31:0];
    div_next = {new_rem, acc_q[30:0], r_ge};
  end

  // Sign fix and output-half selection
  logic [63:0] prod;
  logic [31:0] quo, rem, result;

  always_comb begin
    prod = neg_q ? (~acc_q + 64'd1) : acc_q;
    quo  = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem  = neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    if (spec_q) begin
      result = acc_q[31:0];
    end else begin
      unique case (op_q)
        OpMul:                     result = prod[31:0];
        OpMulh, OpMulhsu, OpMulhu: result = prod[63:32];
        OpDiv, OpDivu:             result = quo;
        OpRem, OpRemu:             result = rem;
        default:                   result = 32'd0;
      endcase
    end
  end

  // Next-state logic; accept is a registered request resolved on the following edge
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    spec_d  = spec_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addd_d  = addd_q;

    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          pend_d = 1'b0;
          cnt_d  = 5'd0;
          neg_d  = neg_res;
          spec_d = special;
          if (special) begin
            acc_d   = {32'd0, spec_val};
            state_d = StFix;
          end else begin
            opnd_d  = is_div ? mag_b : mag_a;
            acc_d   = {32'd0, is_div ? mag_a : mag_b};
            state_d = StCalc;
          end
        end else if (start) begin
          pend_d = 1'b1;
          op_d   = funct3;
          a_d    = DataA;
          b_d    = DataB;
          rd_d   = rd;
        end
      end
      StCalc: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StFix;
        end
      end
      StFix: begin
        data_d  = result;
        addd_d  = rd_q;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rd_q    <= 5'd0;
      acc_q   <= 64'd0;
      opnd_q  <= 32'd0;
      neg_q   <= 1'b0;
      spec_q  <= 1'b0;
      cnt_q   <= 5'd0;
      data_q  <= 32'd0;
      addd_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      spec_q  <= spec_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addd_q  <= addd_d;
    end
  end

  assign busy  = (state_q != StIdle) | pend_q;
  assign done  = (state_q == StDone);
  assign WE    = (state_q == StDone) & (addd_q != 5'd0);
  assign AddD  = addd_q;
  assign DataD = data_q;

endmodule
